// File: rtl/light_sequencer.sv
// light_sequencer
//
// Traffic-light style phase sequencer for a game. It steps through
// RED -> GREEN -> (YELLOW ->) RED. The RED and GREEN phase lengths, in seconds,
// are drawn from an external random source at each phase expiry. A prescaler
// turns the system clock into a one-second tick.
//
// Ports
//   clk         : single rising-edge clock
//   reset       : synchronous, active-low (0 = reset)
//   game_active : 1 runs the sequencer, 0 freezes prescaler/state/countdown
//   force_red   : restart RED with RESET_DUR seconds on the next edge
//   LFSR_in     : random value, sampled on the edge where a phase expires
//   red/yellow/green : one-hot decode of the registered phase
//   secs_left   : seconds remaining in the current phase (never reads 0)
//   phase_chg   : one-cycle pulse in the first cycle a new phase is visible
//
// The current FSM state is observable through the one-hot red/yellow/green
// outputs. Those outputs are decoded directly from the state register.
module light_sequencer #(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int LFSR_W      = 16,
    parameter int DUR_W       = 4,
    parameter int MIN_DUR     = 1,
    parameter int MAX_DUR     = 10,
    parameter int YELLOW_EN   = 1,
    parameter int YELLOW_DUR  = 1,
    parameter int RESET_DUR   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              game_active,
    input  logic              force_red,
    input  logic [LFSR_W-1:0] LFSR_in,
    output logic              red,
    output logic              yellow,
    output logic              green,
    output logic [DUR_W-1:0]  secs_left,
    output logic              phase_chg
);

    localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int SPAN  = MAX_DUR - MIN_DUR + 1;

    typedef enum logic [1:0] {
        S_RED    = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2
    } state_t;

    state_t             state_q;
    logic [DUR_W-1:0]   secs_q;
    logic [PRE_W-1:0]   pre_q;
    logic               chg_q;

    logic               tick;
    logic [LFSR_W-1:0]  lfsr_mod;
    logic [DUR_W-1:0]   rand_dur_d;

    // The tick fires in the last prescaler count. Every phase therefore
    // starts with the prescaler at 0: it either wraps on the expiry edge or
    // is cleared by reset/force.
    assign tick = (pre_q == PRE_W'(TICK_CYCLES - 1));

    // Random duration. The remainder is below SPAN, so it always fits DUR_W.
    always_comb begin
        lfsr_mod   = LFSR_in % LFSR_W'(SPAN);
        rand_dur_d = DUR_W'(MIN_DUR) + DUR_W'(lfsr_mod);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RED;
            secs_q  <= DUR_W'(RESET_DUR);
            pre_q   <= '0;
            chg_q   <= 1'b0;
        end else if (force_red) begin
            // A forced restart acts whether or not the game is active. It
            // counts as a phase change only when it leaves a non-RED phase.
            state_q <= S_RED;
            secs_q  <= DUR_W'(RESET_DUR);
            pre_q   <= '0;
            chg_q   <= (state_q != S_RED);
        end else if (!game_active) begin
            chg_q   <= 1'b0;
        end else begin
            chg_q <= 1'b0;
            if (tick) begin
                pre_q <= '0;
            end else begin
                pre_q <= pre_q + PRE_W'(1);
            end

            if (tick) begin
                if (secs_q > DUR_W'(1)) begin
                    secs_q <= secs_q - DUR_W'(1);
                end else begin
                    // Expiry: switch phase and reload on the same edge, so
                    // that secs_left never shows 0.
                    chg_q <= 1'b1;
                    case (state_q)
                        S_RED: begin
                            state_q <= S_GREEN;
                            secs_q  <= rand_dur_d;
                        end
                        S_GREEN: begin
                            if (YELLOW_EN != 0) begin
                                state_q <= S_YELLOW;
                                secs_q  <= DUR_W'(YELLOW_DUR);
                            end else begin
                                state_q <= S_RED;
                                secs_q  <= rand_dur_d;
                            end
                        end
                        S_YELLOW: begin
                            state_q <= S_RED;
                            secs_q  <= rand_dur_d;
                        end
                        default: begin
                            state_q <= S_RED;
                            secs_q  <= DUR_W'(RESET_DUR);
                        end
                    endcase
                end
            end
        end
    end

    assign red       = (state_q == S_RED);
    assign yellow    = (state_q == S_YELLOW);
    assign green     = (state_q == S_GREEN);
    assign secs_left = secs_q;
    assign phase_chg = chg_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Bench for light_sequencer. Two instances share one stimulus stream:
//   A: TICK_CYCLES=4, default durations, YELLOW enabled
//   B: TICK_CYCLES=1, MIN_DUR=2, MAX_DUR=5, YELLOW disabled
// The reference model tracks each phase as (phase, loaded seconds, active
// cycles elapsed). Seconds left are derived from those with plain
// arithmetic: a phase ends after dur*TICK active cycles.
module tb_light_sequencer;

    localparam int A_TICK = 4;
    localparam int A_MIN  = 1;
    localparam int A_MAX  = 10;
    localparam int A_YEN  = 1;
    localparam int B_TICK = 1;
    localparam int B_MIN  = 2;
    localparam int B_MAX  = 5;
    localparam int B_YEN  = 0;
    localparam int YDUR   = 1;
    localparam int RDUR   = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ga;
    logic        frc;
    logic [15:0] lf;

    logic       a_red, a_yel, a_grn, a_chg;
    logic [3:0] a_secs;
    logic       b_red, b_yel, b_grn, b_chg;
    logic [3:0] b_secs;

    light_sequencer #(
        .TICK_CYCLES(A_TICK), .LFSR_W(16), .DUR_W(4), .MIN_DUR(A_MIN),
        .MAX_DUR(A_MAX), .YELLOW_EN(A_YEN), .YELLOW_DUR(YDUR), .RESET_DUR(RDUR)
    ) dut_a (
        .clk(clk), .reset(rst_n), .game_active(ga), .force_red(frc),
        .LFSR_in(lf), .red(a_red), .yellow(a_yel), .green(a_grn),
        .secs_left(a_secs), .phase_chg(a_chg)
    );

    light_sequencer #(
        .TICK_CYCLES(B_TICK), .LFSR_W(16), .DUR_W(4), .MIN_DUR(B_MIN),
        .MAX_DUR(B_MAX), .YELLOW_EN(B_YEN), .YELLOW_DUR(YDUR), .RESET_DUR(RDUR)
    ) dut_b (
        .clk(clk), .reset(rst_n), .game_active(ga), .force_red(frc),
        .LFSR_in(lf), .red(b_red), .yellow(b_yel), .green(b_grn),
        .secs_left(b_secs), .phase_chg(b_chg)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    // ---------------- reference model ----------------
    // ph: 0 = RED, 1 = GREEN, 2 = YELLOW
    typedef struct packed {
        int   ph;
        int   dur;
        int   el;
        logic chg;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;

    function automatic mdl_t mdl_next(mdl_t m, int tick, int mn, int mx, int yen,
                                      logic r_n, logic act, logic f, int lfv);
        mdl_t n;
        int   rnd;
        n     = m;
        n.chg = 1'b0;
        rnd   = mn + (lfv % (mx - mn + 1));
        if (!r_n) begin
            n.ph = 0; n.dur = RDUR; n.el = 0;
        end else if (f) begin
            n.chg = (m.ph != 0);
            n.ph = 0; n.dur = RDUR; n.el = 0;
        end else if (act) begin
            n.el = m.el + 1;
            if (n.el == m.dur * tick) begin
                n.el  = 0;
                n.chg = 1'b1;
                if (m.ph == 0) begin
                    n.ph = 1; n.dur = rnd;
                end else if (m.ph == 1 && yen != 0) begin
                    n.ph = 2; n.dur = YDUR;
                end else begin
                    n.ph = 0; n.dur = rnd;
                end
            end
        end
        return n;
    endfunction

    initial begin
        ma = '{ph: 0, dur: RDUR, el: 0, chg: 1'b0};
        mb = '{ph: 0, dur: RDUR, el: 0, chg: 1'b0};
    end

    always @(posedge clk) begin
        ma = mdl_next(ma, A_TICK, A_MIN, A_MAX, A_YEN, rst_n, ga, frc, int'(lf));
        mb = mdl_next(mb, B_TICK, B_MIN, B_MAX, B_YEN, rst_n, ga, frc, int'(lf));
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input string name, input logic r, input logic y, input logic g,
                           input logic [3:0] s, input logic c, input mdl_t m, input int tick);
        logic [7:0] act;
        logic [7:0] exp;
        act = {r, y, g, s, c};
        exp = {m.ph == 0, m.ph == 2, m.ph == 1, 4'(m.dur - m.el / tick), m.chg};
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL model_%s: got ryg=%b%b%b secs=%0d chg=%b expected ryg=%b%b%b secs=%0d chg=%b at %0t",
                     name, act[7], act[6], act[5], act[4:1], act[0],
                     exp[7], exp[6], exp[5], exp[4:1], exp[0], $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut("A", a_red, a_yel, a_grn, a_secs, a_chg, ma, A_TICK);
            cmp_dut("B", b_red, b_yel, b_grn, b_secs, b_chg, mb, B_TICK);
        end
    end

    // ---------------- driver ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        bit found;
        rst_n = 1'b0; ga = 1'b0; frc = 1'b0; lf = 16'd25;

        // Reset held for two cycles.
        step(1);
        chk_en = 1'b1;
        step(1);
        check("rst_red",    a_red,  1);
        check("rst_yellow", a_yel,  0);
        check("rst_green",  a_grn,  0);
        check("rst_secs",   a_secs, 3);
        check("rst_chg",    a_chg,  0);
        check("rst_b_secs", b_secs, 3);

        // RED lasts 3 s * 4 cycles, then GREEN with 1 + 25 mod 10 = 6 s.
        rst_n = 1'b1; ga = 1'b1;
        step(11);
        check("red_last_red",  a_red,  1);
        check("red_last_secs", a_secs, 1);
        step(1);
        check("green_on",   a_grn,  1);
        check("green_secs", a_secs, 6);
        check("green_chg",  a_chg,  1);
        step(1);
        check("green_chg_drop", a_chg, 0);

        // Freeze for 10 cycles mid-phase.
        ga = 1'b0;
        step(10);
        check("freeze_green", a_grn,  1);
        check("freeze_secs",  a_secs, 6);
        check("freeze_chg",   a_chg,  0);
        ga = 1'b1;

        // 24 active cycles of GREEN in total; 1 was spent before the freeze.
        step(22);
        check("green_last_green", a_grn,  1);
        check("green_last_secs",  a_secs, 1);
        lf = 16'd37;
        step(1);
        check("yellow_on",   a_yel,  1);
        check("yellow_secs", a_secs, 1);
        check("yellow_chg",  a_chg,  1);
        step(3);
        check("yellow_hold", a_yel, 1);
        step(1);
        check("y2r_red",  a_red,  1);
        check("y2r_secs", a_secs, 8);
        check("y2r_chg",  a_chg,  1);

        // force_red while already RED: reload without a phase change.
        frc = 1'b1;
        step(1);
        frc = 1'b0;
        check("frc_red_secs", a_secs, 3);
        check("frc_red_chg",  a_chg,  0);

        // force_red during GREEN.
        step(12);
        check("green2_on", a_grn, 1);
        step(2);
        frc = 1'b1;
        step(1);
        frc = 1'b0;
        check("frc_grn_red",  a_red,  1);
        check("frc_grn_secs", a_secs, 3);
        check("frc_grn_chg",  a_chg,  1);

        // Run to YELLOW, then reset inside it.
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (a_yel === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_yellow", found, 1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("rst_in_yel_red",  a_red,  1);
        check("rst_in_yel_secs", a_secs, 3);
        check("rst_in_yel_chg",  a_chg,  0);

        // Instance B: 16'hFFFF mod 4 = 3, so the loaded duration is 2 + 3 = 5.
        frc = 1'b1;
        step(1);
        frc = 1'b0;
        lf = 16'hFFFF;
        step(3);
        check("b_green",    b_grn,  1);
        check("b_max_secs", b_secs, 5);
        check("b_chg",      b_chg,  1);

        // Randomized run against the model.
        for (int i = 0; i < 4000; i++) begin
            ga    = ($urandom_range(0, 9) != 0);
            frc   = ($urandom_range(0, 149) == 0);
            rst_n = ($urandom_range(0, 599) != 0);
            case ($urandom_range(0, 7))
                0:       lf = 16'hFFFF;
                1:       lf = 16'h0000;
                default: lf = 16'($urandom);
            endcase
            step(1);
        end
        frc = 1'b0; rst_n = 1'b1; ga = 1'b1;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
